// File: rtl/heap_pkg.sv
// Shared definitions for the heap command initiator: op/err encodings, FSM states,
// default widths and the command legality check.
package heap_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 10;

  localparam logic [1:0] HEAP_NOP_MAKE = 2'b00;
  localparam logic [1:0] HEAP_PUSH     = 2'b01;
  localparam logic [1:0] HEAP_POP      = 2'b10;
  localparam logic [1:0] HEAP_RSVD     = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_REJECT  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_RESP
  } heap_state_e;

  // A push into a full heap, a pop from an empty heap and the reserved op never reach heap_control.
  function automatic logic op_legal(input logic [1:0] op, input logic is_full, input logic is_empty);
    case (op)
      HEAP_NOP_MAKE: op_legal = 1'b1;
      HEAP_PUSH:     op_legal = !is_full;
      HEAP_POP:      op_legal = !is_empty;
      default:       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/heap_cmd_initiator_if.sv
// Command/response streams plus the heap_control pulse interface in one bundle.
// master = the initiator, slave = system logic and heap_control together.
interface heap_cmd_initiator_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_key;

  logic              hc_start;
  logic [1:0]        hc_instruction;
  logic [DATA_W-1:0] hc_key;
  logic              hc_done;
  logic [DATA_W-1:0] hc_arr_out;
  logic [CNT_W-1:0]  hc_n;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  rsp_count;
  logic [1:0]        rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_key, hc_done, hc_arr_out, hc_n, rsp_ready,
    output cmd_ready, hc_start, hc_instruction, hc_key,
           rsp_valid, rsp_op, rsp_data, rsp_count, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_key, hc_done, hc_arr_out, hc_n, rsp_ready,
    input  cmd_ready, hc_start, hc_instruction, hc_key,
           rsp_valid, rsp_op, rsp_data, rsp_count, rsp_err
  );
endinterface

// File: rtl/heap_timeout_ctr.sv
// Clearable up-counter that flags when TIMEOUT cycles have elapsed since the last clear.
module heap_timeout_ctr #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at the terminal count so a stuck wait never wraps back to "fresh".
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + 1'b1;
  end

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/heap_cmd_initiator.sv
// Turns valid/ready heap commands into heap_control start pulses and returns one
// response per command, with overflow/underflow rejection and per-wait timeouts.
module heap_cmd_initiator
  import heap_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int CAPACITY = 1023,
  parameter int TIMEOUT  = 4096
) (
  input logic clk,
  input logic reset,
  heap_cmd_initiator_if.master bus
);
  // state        | meaning
  // ST_IDLE      | cmd_ready high, legality check on handshake
  // ST_ISSUE     | hc_start pulse, instruction/key presented
  // ST_WAIT_LOW  | drain stale done level from the previous op
  // ST_WAIT_HIGH | wait for completion, capture data/count
  // ST_RESP      | response held until rsp_ready

  heap_state_e       state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              hc_start_q, hc_start_d;
  logic [1:0]        hc_instr_q, hc_instr_d;
  logic [DATA_W-1:0] hc_key_q, hc_key_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_op_q, rsp_op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  rsp_count_q, rsp_count_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic tmo_clr, tmo_en, tmo_tc;
  logic is_full, is_empty;

  assign is_full  = (bus.hc_n == CNT_W'(CAPACITY));
  assign is_empty = (bus.hc_n == '0);
  assign tmo_en   = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH);

  heap_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    hc_start_d  = 1'b0;
    hc_instr_d  = hc_instr_q;
    hc_key_d    = hc_key_q;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_count_d = rsp_count_q;
    rsp_err_d   = rsp_err_q;
    tmo_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          rsp_op_d = bus.cmd_op;
          if (op_legal(bus.cmd_op, is_full, is_empty)) begin
            state_d    = ST_ISSUE;
            hc_start_d = 1'b1;
            hc_instr_d = bus.cmd_op;
            hc_key_d   = bus.cmd_key;
          end else begin
            state_d     = ST_RESP;
            rsp_err_d   = ERR_REJECT;
            rsp_data_d  = '0;
            rsp_count_d = bus.hc_n;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_LOW;
        tmo_clr = 1'b1;
      end
      ST_WAIT_LOW: begin
        if (!bus.hc_done) begin
          state_d = ST_WAIT_HIGH;
          tmo_clr = 1'b1;
        end else if (tmo_tc) begin
          state_d     = ST_RESP;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_data_d  = '0;
          rsp_count_d = bus.hc_n;
        end
      end
      ST_WAIT_HIGH: begin
        // Completion wins over a timeout landing in the same cycle.
        if (bus.hc_done) begin
          state_d     = ST_RESP;
          rsp_err_d   = ERR_OK;
          rsp_data_d  = (rsp_op_q == HEAP_POP) ? bus.hc_arr_out : '0;
          rsp_count_d = bus.hc_n;
        end else if (tmo_tc) begin
          state_d     = ST_RESP;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_data_d  = '0;
          rsp_count_d = bus.hc_n;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      hc_start_q  <= 1'b0;
      hc_instr_q  <= HEAP_NOP_MAKE;
      hc_key_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= HEAP_NOP_MAKE;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      hc_start_q  <= hc_start_d;
      hc_instr_q  <= hc_instr_d;
      hc_key_q    <= hc_key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_count_q <= rsp_count_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.hc_start       = hc_start_q;
  assign bus.hc_instruction = hc_instr_q;
  assign bus.hc_key         = hc_key_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_op         = rsp_op_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_count      = rsp_count_q;
  assign bus.rsp_err        = rsp_err_q;
endmodule

// File: tb/tb_heap_cmd_initiator.sv
// Directed bench for heap_cmd_initiator against a small behavioral heap_control model.
module tb_heap_cmd_initiator;
  localparam int DW  = 32;
  localparam int CW  = 10;
  localparam int TMO = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  heap_cmd_initiator_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  heap_cmd_initiator #(
    .DATA_W   (DW),
    .CNT_W    (CW),
    .CAPACITY (1023),
    .TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // heap_control model controls, written only by the stimulus process
  int          m_lat   = 3;
  int          m_stale = 1;
  bit          m_hang  = 1'b0;
  int          abort_req = 0;
  bit          n_force_en = 1'b0;
  logic [CW-1:0] n_force_val = '0;

  // heap_control model state, written only by the model process
  logic [DW-1:0] keys [0:1023];
  logic [CW-1:0] m_n = '0;
  int            start_cnt = 0;

  assign bus.hc_n = n_force_en ? n_force_val : m_n;

  initial begin : heap_model
    int            pre_keys [10];
    int            abort_seen;
    bit            busy;
    int            cnt;
    int            best;
    logic [1:0]    op;
    logic [DW-1:0] key;
    pre_keys = '{5, 12, 97, 33, 8, 41, 2, 60, 19, 70};
    for (int i = 0; i < 10; i++) keys[i] = DW'(pre_keys[i]);
    m_n            = CW'(10);
    abort_seen     = 0;
    busy           = 1'b0;
    cnt            = 0;
    bus.hc_done    = 1'b1;
    bus.hc_arr_out = '0;
    forever begin
      @(negedge clk);
      if (abort_req != abort_seen) begin
        abort_seen  = abort_req;
        busy        = 1'b0;
        bus.hc_done = 1'b1;
      end else if (bus.hc_start) begin
        busy = 1'b1;
        cnt  = 0;
        op   = bus.hc_instruction;
        key  = bus.hc_key;
        start_cnt++;
      end else if (busy) begin
        cnt++;
        if (cnt == m_stale) bus.hc_done = 1'b0;
        if (cnt >= m_lat && !m_hang) begin
          bus.hc_arr_out = 32'hDEAD_BEEF;
          if (op == 2'b01) begin
            keys[m_n] = key;
            m_n = m_n + 1'b1;
          end else if (op == 2'b10) begin
            best = 0;
            for (int i = 1; i < int'(m_n); i++) if (keys[i] > keys[best]) best = i;
            bus.hc_arr_out = keys[best];
            keys[best] = keys[m_n - 1'b1];
            m_n = m_n - 1'b1;
          end
          bus.hc_done = 1'b1;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the command handshake edge.
  task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] key);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_key   = key;
    w = 0;
    while (!bus.cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Counts edges after the handshake until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < TMO + 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_rsp(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] op, input logic [DW-1:0] data,
                         input logic [CW-1:0] count, input logic [1:0] err);
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    chk({tag, "_op"},    bus.rsp_op,    op);
    chk({tag, "_data"},  bus.rsp_data,  data);
    chk({tag, "_count"}, bus.rsp_count, count);
    chk({tag, "_err"},   bus.rsp_err,   err);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int s;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_key   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_hc_start",  bus.hc_start, 0);
    chk("rst_hc_instr",  bus.hc_instruction, 0);
    chk("rst_hc_key",    bus.hc_key, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_op",    bus.rsp_op, 0);
    chk("rst_rsp_data",  bus.rsp_data, 0);
    chk("rst_rsp_count", bus.rsp_count, 0);
    chk("rst_rsp_err",   bus.rsp_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);

    // make-heap
    s = start_cnt;
    send_cmd(2'b00, 32'h0);
    chk("make_hc_start", bus.hc_start, 1);
    chk("make_hc_instr", bus.hc_instruction, 0);
    wait_rsp(lat);
    chk("make_lat", lat, 4);
    chk("make_start_pulses", start_cnt - s, 1);
    chk_rsp("make", 2'b00, 32'h0, 10'd10, 2'b00);
    take_rsp(0);
    chk("make_done_cmd_ready", bus.cmd_ready, 1);
    chk("make_done_rsp_valid", bus.rsp_valid, 0);

    // push 15
    send_cmd(2'b01, 32'd15);
    chk("push_hc_key", bus.hc_key, 15);
    chk("push_hc_instr", bus.hc_instruction, 1);
    wait_rsp(lat);
    chk("push_key_held", bus.hc_key, 15);
    chk_rsp("push", 2'b01, 32'h0, 10'd11, 2'b00);
    take_rsp(0);

    // pop max 97
    send_cmd(2'b10, 32'h1234);
    wait_rsp(lat);
    chk_rsp("pop", 2'b10, 32'd97, 10'd10, 2'b00);
    take_rsp(0);

    // push 97 back, then pop with rsp_ready held low
    send_cmd(2'b01, 32'd97);
    wait_rsp(lat);
    chk_rsp("push97", 2'b01, 32'h0, 10'd11, 2'b00);
    take_rsp(0);
    send_cmd(2'b10, 32'h0);
    wait_rsp(lat);
    repeat (5) @(posedge clk);
    #1;
    chk_rsp("pop_hold", 2'b10, 32'd97, 10'd10, 2'b00);
    chk("pop_hold_cmd_ready", bus.cmd_ready, 0);
    take_rsp(0);

    // pop on empty heap
    n_force_val = 10'd0;
    n_force_en  = 1'b1;
    s = start_cnt;
    send_cmd(2'b10, 32'h0);
    chk("empty_hc_start", bus.hc_start, 0);
    wait_rsp(lat);
    chk("empty_lat", lat, 0);
    chk_rsp("empty", 2'b10, 32'h0, 10'd0, 2'b01);
    take_rsp(0);

    // push on full heap
    n_force_val = 10'd1023;
    send_cmd(2'b01, 32'd5);
    wait_rsp(lat);
    chk("full_lat", lat, 0);
    chk_rsp("full", 2'b01, 32'h0, 10'd1023, 2'b01);
    take_rsp(0);
    n_force_en = 1'b0;

    // reserved op
    send_cmd(2'b11, 32'h0);
    wait_rsp(lat);
    chk_rsp("rsvd", 2'b11, 32'h0, 10'd10, 2'b01);
    take_rsp(0);
    chk("reject_no_start", start_cnt - s, 0);

    // stale done stays high for several cycles after start
    m_stale = 4;
    m_lat   = 6;
    send_cmd(2'b01, 32'd21);
    wait_rsp(lat);
    chk("stale_lat", lat, 7);
    chk_rsp("stale", 2'b01, 32'h0, 10'd11, 2'b00);
    take_rsp(0);
    m_stale = 1;
    m_lat   = 3;
    send_cmd(2'b10, 32'h0);
    wait_rsp(lat);
    chk("pop70_lat", lat, 4);
    chk_rsp("pop70", 2'b10, 32'd70, 10'd10, 2'b00);
    take_rsp(0);

    // heap_control never completes
    m_hang = 1'b1;
    send_cmd(2'b00, 32'h0);
    wait_rsp(lat);
    chk("tmo_lat", lat, TMO + 2);
    chk_rsp("tmo", 2'b00, 32'h0, 10'd10, 2'b10);
    take_rsp(0);
    abort_req++;
    m_hang = 1'b0;
    repeat (2) @(posedge clk);

    // reset in WAIT_HIGH
    m_hang = 1'b1;
    send_cmd(2'b01, 32'd50);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_cmd_ready", bus.cmd_ready, 0);
    chk("midrst_hc_start",  bus.hc_start, 0);
    chk("midrst_hc_instr",  bus.hc_instruction, 0);
    chk("midrst_hc_key",    bus.hc_key, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_rsp_op",    bus.rsp_op, 0);
    abort_req++;
    m_hang = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_rsp_valid", bus.rsp_valid, 0);
    chk("after_rst_cmd_ready", bus.cmd_ready, 1);
    send_cmd(2'b00, 32'h0);
    wait_rsp(lat);
    chk("after_rst_lat", lat, 4);
    chk_rsp("after_rst", 2'b00, 32'h0, 10'd10, 2'b00);
    take_rsp(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
